// File: rtl/dsc_sn2bin_rx_if.sv
// Stream and result bundle for the stochastic-to-binary receiver.
// The master drives the stochastic stream; the slave returns the decoded count.
interface dsc_sn2bin_rx_if #(
    parameter int WIDTH = 6
);
    localparam int ZW = 2 * WIDTH;

    logic          start;
    logic          en;
    logic          sn_in;
    logic [ZW-1:0] z;
    logic          valid;
    logic          busy;

    modport master (
        output start, en, sn_in,
        input  z, valid, busy
    );

    modport slave (
        input  start, en, sn_in,
        output z, valid, busy
    );
endinterface

// File: rtl/dsc_sn2bin_rx.sv
// Framed stochastic-to-binary receiver: counts the ones in a 2^(2*WIDTH)-bit
// qualified frame and reports the saturated count with a one-cycle valid pulse.
module dsc_sn2bin_rx #(
    parameter int WIDTH = 6
) (
    input logic           clk,
    input logic           rst,
    dsc_sn2bin_rx_if.slave bus
);
    localparam int ZW = 2 * WIDTH;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_next;
    logic [ZW-1:0] bit_cnt, bit_cnt_next;
    logic [ZW:0]   ones_cnt, ones_cnt_next;
    logic [ZW:0]   ones_sum;
    logic [ZW-1:0] z_q, z_next;
    logic          valid_q, valid_next;
    logic          last_bit;

    // ones_cnt carries one extra bit so an all-ones frame is exact before saturation.
    assign ones_sum = ones_cnt + (ZW+1)'(bus.sn_in);
    assign last_bit = bus.en && (bit_cnt == {ZW{1'b1}});

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        ones_cnt_next = ones_cnt;
        z_next        = z_q;
        valid_next    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next    = RUN;
                    bit_cnt_next  = '0;
                    ones_cnt_next = '0;
                end
            end
            RUN: begin
                if (bus.en) begin
                    bit_cnt_next  = bit_cnt + ZW'(1);
                    ones_cnt_next = ones_sum;
                    if (last_bit) begin
                        state_next = IDLE;
                        valid_next = 1'b1;
                        z_next     = ones_sum[ZW] ? {ZW{1'b1}} : ones_sum[ZW-1:0];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            ones_cnt <= '0;
            z_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            ones_cnt <= ones_cnt_next;
            z_q      <= z_next;
            valid_q  <= valid_next;
        end
    end

    // busy decodes the state register directly, so it is still free of input paths.
    assign bus.z     = z_q;
    assign bus.valid = valid_q;
    assign bus.busy  = (state == RUN);
endmodule

// File: doc/dsc_sn2bin_rx.md
Name: dsc_sn2bin_rx

Overview:
- Framed stochastic-to-binary receiver: the decoding end of a DSC unary bitstream link.
- Accepts one serial stochastic bit per qualified cycle over a fixed frame of 2^(2*WIDTH) bits and counts the ones.
- Reports the count as a binary value with a one-cycle valid pulse.
- Sits downstream of the DSC multiplier output (or any SNG stream), replacing free-running counters with start/busy/valid framing and saturation.

Parameters:
WIDTH, 6, SNG operand width; frame length FRAME_LEN = 2^(2*WIDTH) bits.
ZW, 2*WIDTH, result width; derived, not overridden.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a new frame (sampled in IDLE only)
en  input  1  stream qualifier; sn_in is valid and the frame advances only when en=1
sn_in  input  1  stochastic bitstream input
z  output  ZW  decoded binary result of last completed frame
valid  output  1  one-cycle pulse: z updated this cycle
busy  output  1  high while a frame is in progress

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, z=0, valid=0, busy=0, bit counter=0, ones counter=0. Reset dominates all other inputs. Reset mid-frame discards the partial frame with no valid pulse.
- State machine:
  - IDLE: busy=0. start=1 -> RUN. On the same edge, bit_cnt and ones_cnt are cleared. sn_in/en in the start cycle are not sampled.
  - RUN: busy=1. Each cycle with en=1: bit_cnt += 1, ones_cnt += sn_in. Cycles with en=0 hold both counters (stall, no timeout).
  - RUN -> IDLE on the edge that samples the final bit (en=1 and bit_cnt == FRAME_LEN-1). On that edge:
    - z <= min(ones_cnt + sn_in, 2^ZW - 1);
    - valid <= 1 for exactly one cycle;
    - busy <= 0.
- Counter widths:
  - bit_cnt is ZW bits; wraps at FRAME_LEN-1 by construction.
  - ones_cnt is ZW+1 bits, so an all-ones frame (count = 2^ZW) is exact internally. It saturates to 2^ZW - 1 only at the output.
- Latency: valid asserts on the edge that samples the last qualified bit. With en held high, valid is high in the cycle FRAME_LEN+1 cycles after the start cycle.
- start while busy=1: ignored, with no restart and no counter effect.
- start in the cycle valid=1: state is already IDLE, so start is accepted and the next frame begins. This allows back-to-back frames with a one-cycle gap.
- z holds its value between valid pulses and does not change during RUN.
- valid never asserts without a completed frame. busy and valid are never both 1.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- WIDTH=3 (FRAME_LEN=64), start pulse, en=1, sn_in=0 constant -> valid pulse 65 cycles after start cycle, z=0, busy high for 64 cycles.
- WIDTH=3, sn_in=1 constant, en=1 -> ones=64 internally, z=63 (saturated), single valid pulse.
- WIDTH=3, sn_in alternating 1,0,..., en=1 -> z=32. Then issue start in the valid cycle with sn_in pattern 1,1,1,0 -> second valid 65 cycles later with z=48.
- WIDTH=3, en toggling 1,0 every cycle, sn_in=1 only on en=0 cycles and 0 on en=1 cycles -> frame takes 128 cycles, z=0 (unqualified bits ignored).
- WIDTH=3, start, after 20 qualified ones assert rst for one cycle -> z=0, busy=0, no valid. Then start mid-IDLE with sn_in=1 for 10 bits, then 0 -> z=10.
- WIDTH=6 default, start then start re-pulsed at cycle 100 with sn_in=1 constant -> single frame only, valid at cycle 4097, z=4095.
